// File: rtl/board_link_pkg.sv
// Shared definitions for the board-to-board checkers link (transmitter and receiver).
// Frame: 256-bit board image, MSB first, followed by one parity bit.
package board_link_pkg;

  localparam int BOARD_W    = 256;
  localparam int FRAME_BITS = BOARD_W + 1;

  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic {
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  localparam parity_t PARITY_TYPE = PAR_EVEN;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    SETUP,
    HIGH,
    LOW,
    DONE
  } tx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous input line.
// Output follows the input after SYNC_STAGES rising edges of clk.
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/board_link_tx.sv
// Serial transmitter for the board link: latches a board image, waits for the
// peer, then clocks out data MSB first plus a parity bit on a generated sclk.
module board_link_tx
  import board_link_pkg::*;
#(
  parameter int DATA_W      = BOARD_W,
  parameter int HALF_PERIOD = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send_req,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              peer_ready,
  output logic              sclk_out,
  output logic              sdata_out,
  output logic              tx_active,
  output logic              busy,
  output logic              done,
  output logic              abort_err,
  output logic [8:0]        bit_idx
);

  localparam int              HC_W       = $clog2(HALF_PERIOD);
  localparam logic [HC_W-1:0] HC_LAST    = HC_W'(HALF_PERIOD - 1);
  localparam logic [8:0]      IDX_PARITY = 9'(DATA_W);
  localparam logic [8:0]      IDX_LAST   = 9'(DATA_W + 1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shreg_q;
  logic              parity_q;
  logic [HC_W-1:0]   hc_q;
  logic              sclk_q, sdata_q, tx_active_q, busy_q, done_q, abort_q;
  logic [8:0]        bit_idx_q;
  logic              pr_s;
  logic              hc_wrap;
  logic              next_bit;
  logic              in_frame;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pr_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (peer_ready),
    .q_o  (pr_s)
  );

  assign hc_wrap  = (hc_q == HC_LAST);
  assign in_frame = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW);
  // The bit after the last data bit is the parity bit, not the (now empty) shift MSB.
  assign next_bit = (bit_idx_q == IDX_PARITY) ? parity_q : shreg_q[DATA_W-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      parity_q    <= 1'b0;
      hc_q        <= '0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      tx_active_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      bit_idx_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      // Peer loss takes priority over every in-frame transition, including the final one.
      if (in_frame && !pr_s) begin
        state_q     <= IDLE;
        abort_q     <= 1'b1;
        sclk_q      <= 1'b0;
        sdata_q     <= 1'b0;
        tx_active_q <= 1'b0;
        busy_q      <= 1'b0;
        bit_idx_q   <= '0;
        hc_q        <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (send_req) begin
              shreg_q     <= tx_data;
              parity_q    <= (^tx_data) ^ (PARITY_TYPE == PAR_ODD);
              tx_active_q <= 1'b1;
              busy_q      <= 1'b1;
              bit_idx_q   <= '0;
              state_q     <= WAIT_READY;
            end
          end
          WAIT_READY: begin
            if (pr_s) begin
              sdata_q <= shreg_q[DATA_W-1];
              hc_q    <= '0;
              state_q <= SETUP;
            end
          end
          SETUP, LOW: begin
            if (hc_wrap) begin
              hc_q      <= '0;
              sclk_q    <= 1'b1;
              bit_idx_q <= bit_idx_q + 9'd1;
              state_q   <= HIGH;
            end else begin
              hc_q <= hc_q + HC_W'(1);
            end
          end
          HIGH: begin
            if (hc_wrap) begin
              hc_q   <= '0;
              sclk_q <= 1'b0;
              if (bit_idx_q == IDX_LAST) begin
                done_q      <= 1'b1;
                sdata_q     <= 1'b0;
                tx_active_q <= 1'b0;
                state_q     <= DONE;
              end else begin
                shreg_q <= shreg_q << 1;
                sdata_q <= next_bit;
                state_q <= LOW;
              end
            end else begin
              hc_q <= hc_q + HC_W'(1);
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sclk_out  = sclk_q;
  assign sdata_out = sdata_q;
  assign tx_active = tx_active_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign abort_err = abort_q;
  assign bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_board_link_tx.sv
// Directed bench for board_link_tx: frame contents, parity, peer wait, abort,
// ignored requests and asynchronous reset, with hand-computed expectations.
module tb_board_link_tx;

  localparam int DW = 256;
  localparam int HP = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          send_req = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          peer_ready = 1'b0;
  logic          sclk_out, sdata_out, tx_active, busy, done, abort_err;
  logic [8:0]    bit_idx;

  always #5 clk = ~clk;

  board_link_tx #(.DATA_W(DW), .HALF_PERIOD(HP), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .send_req  (send_req),
    .tx_data   (tx_data),
    .peer_ready(peer_ready),
    .sclk_out  (sclk_out),
    .sdata_out (sdata_out),
    .tx_active (tx_active),
    .busy      (busy),
    .done      (done),
    .abort_err (abort_err),
    .bit_idx   (bit_idx)
  );

  int          n_pass = 0;
  int          n_chk = 0;
  int          edge_cnt = 0;
  logic [DW:0] cap = '0;
  int          done_cnt = 0;
  int          abort_cnt = 0;

  // Receiver model: sample data on each serial-clock rising edge.
  always @(posedge sclk_out) begin
    edge_cnt <= edge_cnt + 1;
    cap      <= {cap[DW-1:0], sdata_out};
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (abort_err === 1'b1) abort_cnt <= abort_cnt + 1;
  end

  task automatic chk(input string tag, input logic [DW+3:0] obs, input logic [DW+3:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [DW-1:0] d);
    @(negedge clk);
    tx_data  = d;
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic wait_done(output int n, output logic pta);
    n   = 0;
    pta = 1'b0;
    while (done !== 1'b1 && n < 6000) begin
      pta = tx_active;
      @(negedge clk);
      n++;
    end
  endtask

  int          e0, dc0, ac0, n, viol;
  logic        pta;
  logic [DW-1:0] d;

  initial begin
    peer_ready = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {sclk_out, sdata_out, tx_active, busy, done, abort_err}, 0);
    chk("reset_bit_idx", bit_idx, 0);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame: MSB and LSB set, even ones-count
    d  = {1'b1, 254'b0, 1'b1};
    e0 = edge_cnt;
    send(d);
    wait_done(n, pta);
    chk("t1_latency", n, 1 + 514 * HP);
    chk("t1_txact_at_done", tx_active, 0);
    chk("t1_txact_before_done", pta, 1);
    chk("t1_busy_at_done", busy, 1);
    chk("t1_bit_idx_held", bit_idx, 257);
    chk("t1_edges", edge_cnt - e0, 257);
    chk("t1_frame", cap, {d, 1'b0});
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_bit_idx", bit_idx, 257);

    // Parity of an odd and an even ones-count
    repeat (3) @(negedge clk);
    d = 256'h1;
    send(d);
    wait_done(n, pta);
    chk("t2_done_seen", done, 1);
    chk("t2_frame_odd", cap, {d, 1'b1});
    repeat (3) @(negedge clk);
    d = {DW{1'b1}};
    send(d);
    wait_done(n, pta);
    chk("t2_frame_even", cap, {d, 1'b0});

    // Wait for the peer
    @(negedge clk);
    peer_ready = 1'b0;
    repeat (5) @(negedge clk);
    d  = {8{32'hDEADBEEF}};
    e0 = edge_cnt;
    send(d);
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_active !== 1'b1 || sclk_out !== 1'b0 || sdata_out !== 1'b0) viol++;
    end
    chk("t3_wait_outputs", viol, 0);
    peer_ready = 1'b1;
    n = 0;
    while (sclk_out !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t3_first_rise", n, SS + 1 + HP);
    wait_done(n, pta);
    chk("t3_edges", edge_cnt - e0, 257);
    chk("t3_frame", cap, {d, 1'b0});

    // Abort after the 40th rising edge
    repeat (3) @(negedge clk);
    e0  = edge_cnt;
    dc0 = done_cnt;
    ac0 = abort_cnt;
    send({128'h0, {128{1'b1}}});
    n = 0;
    while (edge_cnt - e0 < 40 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    peer_ready = 1'b0;
    n = 0;
    while (abort_err !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_abort_latency", n, SS + 1);
    chk("t4_abort_outputs", {sclk_out, sdata_out, tx_active, busy}, 0);
    chk("t4_abort_bit_idx", bit_idx, 0);
    @(negedge clk);
    chk("t4_abort_pulse_len", abort_err, 0);
    repeat (40) @(negedge clk);
    chk("t4_no_more_edges", edge_cnt - e0, 40);
    chk("t4_no_done", done_cnt - dc0, 0);
    chk("t4_one_abort", abort_cnt - ac0, 1);

    // Ignored request and data change mid-frame, request during DONE
    peer_ready = 1'b1;
    repeat (5) @(negedge clk);
    dc0 = done_cnt;
    d   = 256'h7;
    send(d);
    repeat (500) @(negedge clk);
    tx_data  = '0;
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    wait_done(n, pta);
    chk("t5_frame", cap, {d, 1'b1});
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    chk("t5_done_req_ignored", {busy, tx_active}, 0);
    repeat (20) @(negedge clk);
    chk("t5_still_idle", busy, 0);
    chk("t5_one_done", done_cnt - dc0, 1);

    // Asynchronous reset in the middle of a HIGH phase
    e0 = edge_cnt;
    d  = {8{32'h12345678}};
    send(d);
    n = 0;
    while (!(edge_cnt - e0 >= 10 && sclk_out === 1'b1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {sclk_out, sdata_out, tx_active, busy, done, abort_err}, 0);
    chk("t6_reset_bit_idx", bit_idx, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_idle_after_reset", {busy, tx_active, sclk_out}, 0);
    e0 = edge_cnt;
    send(d);
    wait_done(n, pta);
    chk("t6_done_seen", done, 1);
    chk("t6_edges", edge_cnt - e0, 257);
    chk("t6_frame", cap, {d, 1'b0});

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/board_link_tx.md
Name: board_link_tx

Overview:
- Serial transmitter for the board-to-board checkers link.
- Latches a 256-bit board image from the Nios send rows and shifts it out over GPIO on a generated serial clock, followed by an even-parity bit.
- Waits for the peer's ready-for-receive line and aborts cleanly if that line drops mid-frame.
- Sits between the Nios row outputs and the GPIO pins (clock-out, data-out, transmit-active).

Parameters:
- DATA_W, 256, board image width in bits (8 rows x 32).
- HALF_PERIOD, 4, clk cycles per serial-clock half period (must be >= 2).
- SYNC_STAGES, 2, flip-flop depth of the peer_ready synchroniser.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- send_req  in  1  one-cycle request to transmit; sampled only in IDLE.
- tx_data  in  DATA_W  board image; captured on the cycle send_req is accepted.
- peer_ready  in  1  peer's ready-for-receive line from GPIO; asynchronous, synchronised internally.
- sclk_out  out  1  serial clock to the peer; the receiver samples on its rising edge.
- sdata_out  out  1  serial data, MSB first; changes only while sclk_out is low.
- tx_active  out  1  high from request acceptance until the frame ends or aborts; drives the transmit-active GPIO line.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- abort_err  out  1  one-cycle pulse when a frame aborts.
- bit_idx  out  9  bits already sent (0..257); for debug and LEDs.

Behaviour:
- Reset (async, rst_n low): state IDLE; sclk_out, sdata_out, tx_active, busy, done and abort_err all 0; bit_idx 0; shift register 0; synchroniser flops 0.
- peer_ready passes through SYNC_STAGES flops; pr_s denotes the synchronised value. Latency is SYNC_STAGES cycles.
- States: IDLE, WAIT_READY, SETUP, HIGH, LOW, DONE. Half-period counter hc counts 0..HALF_PERIOD-1.
- IDLE:
  - send_req=1 loads shreg <= tx_data and parity <= ^tx_data, sets tx_active=1, goes to WAIT_READY.
  - send_req while busy is ignored; it is not queued.
- WAIT_READY:
  - Waits indefinitely for pr_s=1. sclk_out=0, sdata_out=0.
  - On pr_s=1, drives sdata_out <= shreg[DATA_W-1] and goes to SETUP with hc=0.
- SETUP: sclk_out=0 for HALF_PERIOD cycles, then goes to HIGH.
- HIGH:
  - sclk_out=1 for HALF_PERIOD cycles; bit_idx increments on entry.
  - On exit: if bit_idx==DATA_W+1, go to DONE. Otherwise go to LOW, shift shreg left by 1, and drive sdata_out with the next bit. The next bit is shreg MSB after the shift, or parity when bit_idx==DATA_W.
- LOW: sclk_out=0 for HALF_PERIOD cycles, then goes to HIGH.
- DONE:
  - Single cycle. done=1; sclk_out, sdata_out and tx_active return to 0; bit_idx is held for inspection.
  - Next state is IDLE. bit_idx is cleared on the next acceptance.
- Frame length: 257 rising edges (256 data bits MSB first, then the parity bit). Time from SETUP entry to DONE is 514*HALF_PERIOD cycles.
- Parity: even parity, i.e. the XOR of all 256 data bits. The ones-count of the 257-bit frame is even.
- Abort:
  - In SETUP, HIGH or LOW, pr_s=0 on any cycle forces the next state to IDLE.
  - On that transition: abort_err pulses for 1 cycle, sclk_out=0, sdata_out=0, tx_active=0, bit_idx reset to 0. No partial rising edge is generated after the abort cycle.
- Simultaneous events:
  - An abort that coincides with the final HIGH exit is treated as abort, not done.
  - send_req in the DONE cycle is ignored.
- tx_data changes after capture do not affect the frame in flight.
- All outputs are registered; sclk_out is glitch-free.
- Reset mid-frame returns to IDLE immediately with all outputs at 0.

Decomposition:
- Package board_link_pkg:
  - BOARD_W=256 and FRAME_BITS=257.
  - State enum tx_state_t.
  - Shared frame-format constants (MSB-first flag, parity type) for reuse by the matching receiver.
- Sub-module bit_sync:
  - Parameterised SYNC_STAGES flip-flop synchroniser.
  - Async active-low reset to 0.
  - Also reused by the receiver for its clock-in and data-in lines.

Test Plan:
- Basic frame, HALF_PERIOD=4: tx_data=256'h8000...0001, peer_ready held 1, send_req pulse.
  - Expect 257 sclk rising edges and captured bits 1,0...0,1 followed by parity 0.
  - Expect done exactly 2056 cycles after SETUP entry, with tx_active falling on the same edge.
- Parity: tx_data=256'h1 (odd ones-count) -> 257th sampled bit is 1. tx_data=all-ones (256 ones) -> 257th bit is 0.
- Wait for peer: peer_ready=0 at send_req; raise it after 100 cycles.
  - tx_active=1 and sclk_out=0 throughout the wait.
  - SETUP begins SYNC_STAGES+1 cycles after the rise.
- Mid-frame abort: drop peer_ready after the 40th rising edge.
  - abort_err pulses once, sclk_out/sdata_out/tx_active go to 0, bit_idx goes to 0.
  - No 41st rising edge appears; done never asserts.
- Ignored request and data stability: pulse send_req again and change tx_data to 256'h0 mid-frame.
  - The frame continues with the originally captured image, and only one done pulse occurs.
- Async reset: assert rst_n=0 mid-HIGH, asynchronous to clk.
  - All outputs are 0 within the same cycle; after release the block sits in IDLE until the next send_req.
